// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a ROWS x COLS switch matrix. One column is driven at a time, and the
//   row sense lines report which keys in that column are closed. A press is
//   accepted only after the synchronized rows have stayed unchanged for
//   DEBOUNCE clocks. A release is accepted only after the rows have read zero
//   for DEBOUNCE clocks.
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous reset, active low
//   row       : raw row sense (asynchronous to clk); a high bit means a closed
//               key in the driven column
//   col       : one-hot column drive
//   code      : accepted key code = row_idx*COLS + col_idx
//   valid     : one-clock pulse when a press is accepted
//   held      : high while an accepted key remains pressed, including the
//               release qualification
//   multi     : set together with valid when more than one row was closed
//   dbg_state : current FSM state (0 scan, 1 debounce, 2 hold, 3 release)
//
// Handshake: valid is a single-cycle strobe with no ready. code and multi
// become valid in the same cycle as the strobe and keep their values until
// the next strobe.
module keypad_scanner #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 16,
  localparam int CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row,
  output logic [COLS-1:0]   col,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              held,
  output logic              multi,
  output logic [1:0]        dbg_state
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HOLD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [ROWS-1:0]   row_s1_q, row_s1_d;
  logic [ROWS-1:0]   row_s2_q, row_s2_d;
  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [COL_W-1:0]  col_idx_q, col_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ROWS-1:0]   cap_q, cap_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              multi_q, multi_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;

  logic [ROWS-1:0]   rs;
  logic              last_dwell;
  logic [COL_W-1:0]  col_next;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_done;
  logic [ROW_W-1:0]  low_row;
  logic [CODE_W-1:0] new_code;
  logic              new_multi;

  assign rs = row_s2_q;

  assign row_s1_d = row;
  assign row_s2_d = row_s1_q;

  assign last_dwell = (div_q == DIV_W'(SCAN_DIV - 1));
  assign col_next   = (col_idx_q == COL_W'(COLS - 1)) ? '0 : col_idx_q + COL_W'(1);

  // Saturating increment, so a stuck condition can never wrap the count
  // back into range and qualify twice.
  assign cnt_inc  = (cnt_q == CNT_W'(DEBOUNCE)) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_done = (cnt_inc == CNT_W'(DEBOUNCE));

  // The lowest closed row wins. Scan from the top down so the last hit is
  // the lowest index.
  always_comb begin
    low_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (cap_q[r]) low_row = ROW_W'(r);
    end
  end

  // col_idx_q is frozen for the whole debounce, so it is the captured column.
  assign new_code  = CODE_W'(low_row) * CODE_W'(COLS) + CODE_W'(col_idx_q);
  assign new_multi = ((cap_q & (cap_q - ROWS'(1))) != '0);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    col_idx_d = col_idx_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    code_d    = code_q;
    multi_d   = multi_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    case (state_q)
      S_SCAN: begin
        if (last_dwell) begin
          div_d = '0;
          if (rs != '0) begin
            cap_d   = rs;
            cnt_d   = '0;
            state_d = S_DEBOUNCE;
          end else begin
            col_idx_d = col_next;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DEBOUNCE: begin
        if (rs == cap_q) begin
          cnt_d = cnt_inc;
          if (cnt_done) begin
            valid_d = 1'b1;
            code_d  = new_code;
            multi_d = new_multi;
            held_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_HOLD;
          end
        end else begin
          cnt_d     = '0;
          div_d     = '0;
          col_idx_d = col_next;
          state_d   = S_SCAN;
        end
      end
      S_HOLD: begin
        // Other keys appearing here are ignored; only an all-clear matters.
        if (rs == '0) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (rs != '0) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_done) begin
            held_d    = 1'b0;
            cnt_d     = '0;
            div_d     = '0;
            col_idx_d = col_next;
            state_d   = S_SCAN;
          end
        end
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_s1_q  <= '0;
      row_s2_q  <= '0;
      state_q   <= S_SCAN;
      div_q     <= '0;
      col_idx_q <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      code_q    <= '0;
      multi_q   <= 1'b0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      row_s1_q  <= row_s1_d;
      row_s2_q  <= row_s2_d;
      state_q   <= state_d;
      div_q     <= div_d;
      col_idx_q <= col_idx_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      code_q    <= code_d;
      multi_q   <= multi_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    col = '0;
    col[col_idx_q] = 1'b1;
  end

  assign code      = code_q;
  assign valid     = valid_q;
  assign held      = held_q;
  assign multi     = multi_q;
  assign dbg_state = state_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of keypad row inputs, range 2-8.
REQ-002 SHALL have parameter COLS, default 4: number of keypad column drive outputs, range 2-8.
REQ-003 SHALL have parameter SCAN_DIV, default 4: clocks each column is driven during scanning, range 2 or more.
REQ-004 SHALL have parameter DEBOUNCE, default 16: consecutive stable clocks needed to accept a press or a release, range 2 or more.
REQ-005 SHALL derive CODE_W = clog2(ROWS*COLS), with a minimum of 1.
REQ-006 clk  input  1  single system clock, rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 row  input  ROWS  raw row sense; bit high = key closed in the currently driven column; asynchronous to clk.
REQ-009 col  output  COLS  one-hot column drive.
REQ-010 code  output  CODE_W  accepted key code = row_idx*COLS + col_idx.
REQ-011 valid  output  1  one-clock pulse when a press is accepted.
REQ-012 held  output  1  high while an accepted key remains pressed.
REQ-013 multi  output  1  high with valid when more than one row bit was set; stays until the next valid.

Function
REQ-014 SHALL pass row through a 2-flop synchronizer; all logic below uses the synchronized value rs.
REQ-015 SHALL implement states SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-016 SCAN: col SHALL advance one-hot every SCAN_DIV clocks and wrap from bit COLS-1 to bit 0.
REQ-017 SCAN: on the last dwell cycle of a column, if rs is nonzero, SHALL capture the column index and rs, freeze col, and enter DEBOUNCE.
REQ-018 DEBOUNCE: SHALL count clocks while rs equals the captured value.
REQ-019 DEBOUNCE: if rs differs before the count reaches DEBOUNCE, SHALL return to SCAN, clear the counter, and advance col to the next column.
REQ-020 DEBOUNCE: when the count reaches DEBOUNCE, SHALL pulse valid for exactly one clock, update code and multi in that same cycle, and enter HOLD.
REQ-021 row_idx SHALL be the lowest-indexed set bit of the captured rs.
REQ-022 HOLD: SHALL assert held and keep col frozen; when rs == 0, SHALL enter RELEASE with the counter cleared.
REQ-023 RELEASE: SHALL count clocks while rs == 0, with held remaining high.
REQ-024 RELEASE: any nonzero rs SHALL return to HOLD with the counter cleared, and SHALL NOT produce a new valid.
REQ-025 RELEASE: when the count reaches DEBOUNCE, SHALL deassert held, enter SCAN, and advance col.
REQ-026 code and multi SHALL hold their values between valid pulses.
REQ-027 valid SHALL never assert on two consecutive clocks; at most one valid is produced per press-release cycle.
REQ-028 counters SHALL saturate and never wrap.
REQ-029 a second key pressed during HOLD SHALL be ignored until release completes.

Reset
REQ-030 while rst is low, asynchronously: state = SCAN, col = one-hot bit 0, code = 0, valid = 0, held = 0, multi = 0, all counters and synchronizer flops = 0.
REQ-031 reset asserted mid-DEBOUNCE or mid-HOLD SHALL abort with no valid pulse; scanning resumes at column 0 on the first clock after rst rises.

Verification
REQ-032 Reset, no key pressed -> col cycles 0001,0010,0100,1000,0001 with SCAN_DIV clocks per step; valid never asserts.
REQ-033 Key row 2/col 3 held 100 clocks, then released (defaults) -> exactly one valid, code = 0xB, multi = 0; held high until DEBOUNCE clocks after release.
REQ-034 Key row 1/col 0 bounces (toggles every 3 clocks for 12 clocks, then stable) -> single valid, code = 0x4, asserted DEBOUNCE clocks after the last bounce edge is synchronized.
REQ-035 Rows 1 and 3 both set on col 2 -> valid with code = 0x6 (row 1) and multi = 1.
REQ-036 Release glitch (row returns high for 2 clocks during RELEASE) -> no second valid; held stays high until a full clean DEBOUNCE interval.
REQ-037 rst pulled low 5 clocks into DEBOUNCE -> no valid, all outputs at reset values; parameter sweep ROWS=2/COLS=8 -> key row 1/col 7 yields code = 15.
